// File: rtl/sweep_decoder.sv
// Sync/sweep classifier: turns captured pulse centers into sync-relative sweep offsets.
// Optional SWEEP_DECODER_STATS_EN builds the miss/overrun statistics counters.
module sweep_decoder #(
    parameter int WIDTH     = 32,
    parameter int MIN_SWEEP = 2000,
    parameter int MAX_SWEEP = 400000,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] counter,
    input  logic [WIDTH-1:0] center_in,
    input  logic             center_ready,
    output logic             center_clr,
    output logic [WIDTH-1:0] sweep_delta,
    output logic             sweep_axis,
    output logic             sweep_valid,
    input  logic             sweep_ack,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    // state | meaning
    // IDLE  | no live sync, next accepted center becomes a sync
    // ARMED | sync_ts holds a live sync, next center is classified against it
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_SWEEP);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_SWEEP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sync_ts, sync_ts_nxt;
    logic             axis, axis_nxt;
    logic             clr_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] delta_nxt;
    logic             sax_nxt;
    logic             accept;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] age;
    logic             sweep_evt;
    logic             miss_evt;
    logic             drop_evt;

    // Blocking acceptance during the clear cycle keeps a still-high ready from being consumed twice.
    assign accept = center_ready & ~center_clr;
    assign d      = center_in - sync_ts;
    assign age    = counter - sync_ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sync_ts     <= '0;
            axis        <= 1'b0;
            center_clr  <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_delta <= '0;
            sweep_axis  <= 1'b0;
        end else begin
            state       <= state_nxt;
            sync_ts     <= sync_ts_nxt;
            axis        <= axis_nxt;
            center_clr  <= clr_nxt;
            sweep_valid <= valid_nxt;
            sweep_delta <= delta_nxt;
            sweep_axis  <= sax_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sync_ts_nxt = sync_ts;
        axis_nxt    = axis;
        clr_nxt     = accept;
        valid_nxt   = sweep_valid & ~sweep_ack;
        delta_nxt   = sweep_delta;
        sax_nxt     = sweep_axis;
        sweep_evt   = 1'b0;
        miss_evt    = 1'b0;
        drop_evt    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    sync_ts_nxt = center_in;
                    axis_nxt    = ~axis;
                    state_nxt   = ARMED;
                end
            end
            ARMED: begin
                if (accept) begin
                    if (d < MIN_W) begin
                        sync_ts_nxt = center_in;
                    end else if (d <= MAX_W) begin
                        sweep_evt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        miss_evt    = 1'b1;
                        sync_ts_nxt = center_in;
                        axis_nxt    = ~axis;
                    end
                end else if (age > MAX_W) begin
                    miss_evt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // An ack on the same edge frees the output register for the new sweep.
        if (sweep_evt) begin
            if (sweep_valid && !sweep_ack) begin
                drop_evt = 1'b1;
            end else begin
                valid_nxt = 1'b1;
                delta_nxt = d;
                sax_nxt   = axis;
            end
        end
    end

`ifdef SWEEP_DECODER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt    <= '0;
            overrun_cnt <= '0;
        end else begin
            if (miss_evt && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (drop_evt && (overrun_cnt != {CNT_W{1'b1}})) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = miss_evt ^ drop_evt;
    assign miss_cnt     = '0;
    assign overrun_cnt  = '0;
`endif

endmodule

// File: tb/tb_sweep_decoder.sv
// Bench for sweep_decoder: directed scenarios plus random centers against an event-level model.
module tb_sweep_decoder;

    localparam int MIN = 2000;
    localparam int MAX = 400000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] counter = '0;
    logic [31:0] center_in = '0;
    logic        center_ready = 1'b0;
    logic        center_clr;
    logic [31:0] sweep_delta;
    logic        sweep_axis;
    logic        sweep_valid;
    logic        sweep_ack = 1'b0;
    logic [7:0]  miss_cnt;
    logic [7:0]  overrun_cnt;

    sweep_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .counter      (counter),
        .center_in    (center_in),
        .center_ready (center_ready),
        .center_clr   (center_clr),
        .sweep_delta  (sweep_delta),
        .sweep_axis   (sweep_axis),
        .sweep_valid  (sweep_valid),
        .sweep_ack    (sweep_ack),
        .miss_cnt     (miss_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit          m_armed, m_axis, m_clr, m_valid, m_vaxis;
    logic [31:0] m_sync, m_delta;
    int          m_miss, m_ov;

    int          clr_pulses;
    logic [31:0] seen_delta;
    logic        seen_axis;

    function automatic int exp_cnt(input int v);
`ifdef SWEEP_DECODER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_axis = 0; m_clr = 0; m_valid = 0; m_vaxis = 0;
        m_sync = '0; m_delta = '0; m_miss = 0; m_ov = 0;
    endfunction

    // Event view of one clock edge, using the current inputs.
    function automatic void model_step();
        bit          acc;
        bit          nv;
        logic [31:0] d;
        logic [31:0] age;
        acc = center_ready && !m_clr;
        nv  = m_valid && !sweep_ack;
        d   = center_in - m_sync;
        age = counter - m_sync;
        if (acc && !m_armed) begin
            m_sync = center_in; m_axis = !m_axis; m_armed = 1;
        end else if (acc) begin
            if (d < MIN) begin
                m_sync = center_in;
            end else if (d <= MAX) begin
                if (m_valid && !sweep_ack) m_ov = (m_ov < 255) ? m_ov + 1 : 255;
                else begin nv = 1; m_delta = d; m_vaxis = m_axis; end
                m_armed = 0;
            end else begin
                m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                m_sync = center_in; m_axis = !m_axis;
            end
        end else if (m_armed && age > MAX) begin
            m_miss  = (m_miss < 255) ? m_miss + 1 : 255;
            m_armed = 0;
        end
        m_clr   = acc;
        m_valid = nv;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("clr", center_clr, m_clr);
        chk("valid", sweep_valid, m_valid);
        if (m_valid) begin
            chk("delta", sweep_delta, m_delta);
            chk("axis", sweep_axis, m_vaxis);
        end
        chk("miss_cnt", miss_cnt, exp_cnt(m_miss));
        chk("overrun_cnt", overrun_cnt, exp_cnt(m_ov));
        if (center_clr) clr_pulses++;
        if (sweep_valid) begin
            seen_delta = sweep_delta;
            seen_axis  = sweep_axis;
        end
        counter = counter + 1;
    endtask

    // Capture stage behaviour: ready stays high through the clear cycle, then drops.
    task automatic present(input logic [31:0] c);
        center_in    = c;
        counter      = c;
        center_ready = 1'b1;
        cyc();
        cyc();
        center_ready = 1'b0;
        cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clr"}, center_clr, 0);
        chk({tag, "_valid"}, sweep_valid, 0);
        chk({tag, "_delta"}, sweep_delta, 0);
        chk({tag, "_axis"}, sweep_axis, 0);
        chk({tag, "_miss"}, miss_cnt, 0);
        chk({tag, "_overrun"}, overrun_cnt, 0);
    endtask

    initial begin
        int          kind;
        logic [31:0] base;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Basic sync then sweep with ack held.
        sweep_ack  = 1'b1;
        clr_pulses = 0;
        seen_delta = '0;
        present(32'd1000);
        present(32'd51000);
        chk("t1_clr_pulses", clr_pulses, 2);
        chk("t1_delta", seen_delta, 50000);
        chk("t1_axis", seen_axis, 1);
        cyc();
        chk("t1_valid_cleared", sweep_valid, 0);

        // Second-station sync moves the reference.
        present(32'd1000);
        present(32'd1500);
        present(32'd81500);
        chk("t2_delta", seen_delta, 80000);
        chk("t2_axis", seen_axis, 0);

        // Counter wrap between sync and sweep.
        present(32'hFFFF_FF00);
        present(32'h0000_FF00);
        chk("t3_delta", seen_delta, 32'h0001_0000);
        chk("t3_axis", seen_axis, 1);

        // Stale sync timeout at the MAX boundary.
        present(32'd0);
        counter = 32'd400000;
        cyc();
        chk("t4_no_miss_at_max", miss_cnt, 0);
        counter = 32'd400001;
        cyc();
        chk("t4_miss", miss_cnt, exp_cnt(1));
        present(32'd500000);
        present(32'd503000);
        chk("t4_restart_delta", seen_delta, 3000);
        chk("t4_restart_axis", seen_axis, 1);

        // Overrun with ack held low; boundary offsets MIN and MAX both count as sweeps.
        sweep_ack = 1'b0;
        present(32'd10000);
        present(32'd12000);
        present(32'd20000);
        present(32'd420000);
        chk("t5_held_delta", seen_delta, 2000);
        chk("t5_held_axis", seen_axis, 0);
        chk("t5_overrun", overrun_cnt, exp_cnt(1));
        sweep_ack = 1'b1;
        cyc();
        sweep_ack = 1'b0;
        chk("t5_ack_clears", sweep_valid, 0);
        sweep_ack = 1'b1;
        cyc();
        sweep_ack = 1'b0;
        chk("t5_idle_ack", sweep_valid, 0);

        // Single clear pulse per center, then async reset mid-ARMED.
        clr_pulses = 0;
        present(32'd100000);
        chk("t6_single_clr", clr_pulses, 1);
        present(32'd105000);
        present(32'd200000);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random centers relative to the live sync.
        for (int i = 0; i < 300; i++) begin
            sweep_ack = 1'($urandom_range(0, 1));
            kind      = int'($urandom_range(0, 3));
            base      = m_armed ? m_sync : counter;
            case (kind)
                0: present(base + 32'($urandom_range(0, MIN - 1)));
                1: present(base + 32'($urandom_range(MIN, MAX)));
                2: present(base + 32'(MAX + 1) + 32'($urandom_range(0, 100000)));
                default: begin
                    counter = base + 32'(MAX - 2) + 32'($urandom_range(0, 4));
                    cyc();
                end
            endcase
            repeat ($urandom_range(0, 3)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
